// File: rtl/beat_sequencer_pkg.sv
// seq_pkg: shared states, tempo encodings and beat width for the beat sequencer
package seq_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, FINISH} state_t;
  localparam logic [1:0] TEMPO_4 = 2'd0;
  localparam logic [1:0] TEMPO_8 = 2'd1;
  localparam logic [1:0] TEMPO_16 = 2'd2;
  localparam logic [1:0] TEMPO_32 = 2'd3;
  localparam int BEAT_W = 12;
  function automatic int unsigned tempo_shift(input logic [1:0] t);
    return t == TEMPO_4 ? 2 : t == TEMPO_8 ? 3 : t == TEMPO_16 ? 4 : 5;
  endfunction
endpackage

// File: rtl/beat_sequencer_tempo_prescaler.sv
// tempo_prescaler: latched tempo divisor and beat-period counter producing the advance pulse
module tempo_prescaler
  import seq_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int DIV_W = $clog2(CLK_FREQ / 4)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run,
  input  logic       i_clear,
  input  logic       i_div_load,
  input  logic [1:0] i_tempo_sel,
  output logic       o_adv
);
  logic [DIV_W:0] r_div, w_div_sel;
  logic [DIV_W-1:0] r_cnt;
  logic w_wrap;
  assign w_div_sel = (DIV_W + 1)'(CLK_FREQ >> tempo_shift(i_tempo_sel));
  assign w_wrap = {1'b0, r_cnt} == r_div - 1'b1;
  assign o_adv = i_run && w_wrap;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_div <= w_div_sel;
    end else begin
      r_cnt <= i_clear ? '0 : i_run ? (w_wrap ? '0 : r_cnt + 1'b1) : r_cnt;
      if (i_div_load) r_div <= w_div_sel;
    end
  end
endmodule

// File: rtl/beat_sequencer.sv
// beat_sequencer: play/pause/stop transport producing ibeatNum/en; SEQ_STEP_MODE_EN adds single-step in PAUSE
module beat_sequencer
  import seq_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BEAT_LEN = 64,
  parameter int DIV_W = $clog2(CLK_FREQ / 4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  input  logic [1:0]        tempo_sel,
`ifdef SEQ_STEP_MODE_EN
  input  logic              step,
`endif
  output logic [BEAT_W-1:0] ibeatNum,
  output logic              en,
  output logic              beat_tick,
  output logic              done
);
  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BEAT_LEN - 1);
  localparam logic [BEAT_W-1:0] PAST = BEAT_W'(BEAT_LEN);
  state_t r_state, w_state;
  logic [BEAT_W-1:0] r_beat, w_beat;
  logic r_en, r_tick, r_done, w_tick, w_done;
  logic w_adv, w_run, w_clear, w_load, w_step_adv, w_end;
  assign w_run = r_state == PLAY && !play && !stop;
  assign w_clear = stop || r_state == IDLE || r_state == FINISH;
  assign w_load = w_adv || (r_state == IDLE && play && !stop);
`ifdef SEQ_STEP_MODE_EN
  assign w_step_adv = w_adv || (r_state == PAUSE && step);
`else
  assign w_step_adv = w_adv;
`endif
  assign w_end = r_beat == LAST && !loop;
  tempo_prescaler #(.CLK_FREQ(CLK_FREQ), .DIV_W(DIV_W)) u_presc (
    .clk        (clk),
    .rst        (rst),
    .i_run      (w_run),
    .i_clear    (w_clear),
    .i_div_load (w_load),
    .i_tempo_sel(tempo_sel),
    .o_adv      (w_adv)
  );
  // play outranks a same-cycle advance or step; stop outranks everything
  always_comb begin
    w_state = r_state;
    w_beat = r_beat;
    w_tick = 1'b0;
    w_done = 1'b0;
    if (stop) begin
      w_state = IDLE;
      w_beat = '0;
    end else if (play) begin
      w_state = r_state == PLAY ? PAUSE : PLAY;
      w_beat = (r_state == IDLE || r_state == FINISH) ? '0 : r_beat;
    end else if (w_step_adv) begin
      w_tick = 1'b1;
      w_beat = r_beat == LAST ? (loop ? '0 : PAST) : r_beat + 1'b1;
      w_state = w_end ? FINISH : r_state;
      w_done = w_end;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat <= '0;
      r_en <= 1'b0;
      r_tick <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state;
      r_beat <= w_beat;
      r_en <= w_state == PLAY || w_state == FINISH;
      r_tick <= w_tick;
      r_done <= w_done;
    end
  end
  assign ibeatNum = r_beat;
  assign en = r_en;
  assign beat_tick = r_tick;
  assign done = r_done;
endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: directed transport scenarios plus random play/stop/tempo traffic against a beat-timing model
module tb_beat_sequencer;
  localparam int CLK = 64;
  localparam int BL = 8;
  localparam int MI = 0, MP = 1, MU = 2, MF = 3;
  logic clk = 1'b0;
  logic rst = 1'b1, play = 1'b0, stop = 1'b0, loop = 1'b0, step = 1'b0;
  logic [1:0] tempo_sel = 2'd0;
  logic [11:0] ibeatNum;
  logic en, beat_tick, done;
  int n_vec = 0, n_bad = 0;
  int m_mode = MI, m_beat = 0, m_cnt = 0, m_len = 16;
  logic m_en = 1'b0, m_tick = 1'b0, m_done = 1'b0;
  beat_sequencer #(.CLK_FREQ(CLK), .BEAT_LEN(BL)) dut (
    .clk      (clk),
    .rst      (rst),
    .play     (play),
    .stop     (stop),
    .loop     (loop),
    .tempo_sel(tempo_sel),
`ifdef SEQ_STEP_MODE_EN
    .step     (step),
`endif
    .ibeatNum (ibeatNum),
    .en       (en),
    .beat_tick(beat_tick),
    .done     (done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic next_beat();
    m_tick = 1'b1;
    if (m_beat < BL - 1) m_beat++;
    else if (loop) m_beat = 0;
    else begin
      m_beat = BL;
      m_mode = MF;
      m_done = 1'b1;
    end
  endtask
  task automatic cycle();
    int nl;
    @(posedge clk);
    nl = CLK >> (2 + int'(tempo_sel));
    m_tick = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_mode = MI; m_beat = 0; m_cnt = 0; m_len = nl;
    end else if (stop) begin
      m_mode = MI; m_beat = 0; m_cnt = 0;
    end else if (play) begin
      if (m_mode == MI || m_mode == MF) begin
        if (m_mode == MI) m_len = nl;
        m_mode = MP; m_beat = 0; m_cnt = 0;
      end else m_mode = m_mode == MP ? MU : MP;
    end else if (m_mode == MP) begin
      m_cnt++;
      if (m_cnt == m_len) begin
        m_cnt = 0;
        m_len = nl;
        next_beat();
      end
    end
`ifdef SEQ_STEP_MODE_EN
    else if (m_mode == MU && step) next_beat();
`endif
    m_en = m_mode == MP || m_mode == MF;
    #1;
    chk("beat", 32'(ibeatNum), 32'(m_beat));
    chk("en", 32'(en), 32'(m_en));
    chk("tick", 32'(beat_tick), 32'(m_tick));
    chk("done", 32'(done), 32'(m_done));
  endtask
  task automatic measure(input int target, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (ibeatNum != 12'(target) && n < 64);
    chk("reach_beat", 32'(ibeatNum), 32'(target));
  endtask
  task automatic run_until_beat(input int b, input int budget);
    for (int i = 0; i < budget && ibeatNum != 12'(b); i++) cycle();
    chk("wait_beat", 32'(ibeatNum), 32'(b));
  endtask
  task automatic pulse_play();
    play = 1'b1;
    cycle();
    play = 1'b0;
  endtask
  initial begin
    int n, n2, n_done;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_beat", 32'(ibeatNum), 0);
    chk("rst_en", 32'(en), 0);
    pulse_play();
    chk("play_en", 32'(en), 1);
    chk("play_beat", 32'(ibeatNum), 0);
    for (int b = 1; b < BL; b++) begin
      measure(b, n);
      chk("beat_period", 32'(n), 16);
      chk("beat_tick", 32'(beat_tick), 1);
    end
    measure(BL, n);
    chk("finish_period", 32'(n), 16);
    chk("finish_en", 32'(en), 1);
    chk("finish_done", 32'(done), 1);
    n_done = 0;
    repeat (20) begin
      cycle();
      n_done += int'(done);
    end
    chk("finish_hold", 32'(ibeatNum), BL);
    chk("done_once", 32'(n_done), 0);
    pulse_play();
    chk("restart_beat", 32'(ibeatNum), 0);
    chk("restart_en", 32'(en), 1);
    loop = 1'b1;
    run_until_beat(BL - 1, 200);
    measure(0, n);
    chk("wrap_period", 32'(n), 16);
    chk("wrap_tick", 32'(beat_tick), 1);
    chk("wrap_done", 32'(done), 0);
    run_until_beat(3, 200);
    repeat (5) cycle();
    pulse_play();
    repeat (100) cycle();
    chk("pause_en", 32'(en), 0);
    chk("pause_beat", 32'(ibeatNum), 3);
    pulse_play();
    measure(4, n);
    chk("resume_latency", 32'(n), 11);
    measure(5, n);
    repeat (3) cycle();
    tempo_sel = 2'd3;
    measure(6, n2);
    chk("tempo_cur_beat", 32'(n2 + 3), 16);
    measure(7, n);
    chk("tempo_next_beat", 32'(n), 2);
    tempo_sel = 2'd0;
    run_until_beat(5, 300);
    stop = 1'b1;
    play = 1'b1;
    cycle();
    stop = 1'b0;
    play = 1'b0;
    chk("stop_beat", 32'(ibeatNum), 0);
    chk("stop_en", 32'(en), 0);
    repeat (3) cycle();
    chk("stop_idle", 32'(en), 0);
`ifdef SEQ_STEP_MODE_EN
    pulse_play();
    run_until_beat(2, 100);
    pulse_play();
    step = 1'b1;
    cycle();
    step = 1'b0;
    chk("step_beat", 32'(ibeatNum), 3);
    chk("step_en", 32'(en), 0);
    chk("step_tick", 32'(beat_tick), 1);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
`endif
    for (int i = 0; i < 3000; i++) begin
      play = $urandom_range(0, 39) == 0;
      stop = $urandom_range(0, 199) == 0;
      step = $urandom_range(0, 7) == 0;
      rst = $urandom_range(0, 999) == 0;
      if ($urandom_range(0, 49) == 0) loop = 1'($urandom);
      if ($urandom_range(0, 29) == 0) tempo_sel = 2'($urandom_range(0, 3));
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
